// File: rtl/spi_command_receiver_if.sv
// Serial and card-side signals of the SPI SD command-frame receiver.
interface spi_command_receiver_if;
  logic        io_SPI_CS;
  logic        io_SPI_DI;
  logic        io_SPI_DO;
  logic        io_DO;
  logic        io_DI;
  logic        io_CommandReadFinished;
  logic        io_ArgumentReadFinished;
  logic        io_ReadSuccess;
  logic [5:0]  io_Command;
  logic [31:0] io_CommandArgument;
  logic [2:0]  io____state;
  logic [2:0]  io____counter;

  modport slave (
    input  io_SPI_CS, io_SPI_DI, io_DO,
    output io_SPI_DO, io_DI, io_CommandReadFinished, io_ArgumentReadFinished,
           io_ReadSuccess, io_Command, io_CommandArgument, io____state, io____counter
  );

  modport master (
    output io_SPI_CS, io_SPI_DI, io_DO,
    input  io_SPI_DO, io_DI, io_CommandReadFinished, io_ArgumentReadFinished,
           io_ReadSuccess, io_Command, io_CommandArgument, io____state, io____counter
  );
endinterface

// File: rtl/spi_command_receiver.sv
// SPI-mode SD 48-bit command-frame deserialiser running on the host SPI clock.
// Optional CRC7 frame check compiled in with SPI_RX_CRC7_CHECK_EN.
module spi_command_receiver (
  input  logic                         clock,
  input  logic                         reset,
  spi_command_receiver_if.slave        bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TXBIT = 3'd1,
    S_CMD   = 3'd2,
    S_ARG   = 3'd3,
    S_CRC   = 3'd4,
    S_END   = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  counter;
  logic [5:0]  command;
  logic [31:0] argument;
  logic [6:0]  crc_rx;
  logic        cmd_done;
  logic        arg_done;
  logic        read_ok;
  logic        crc_ok;
  logic        cs;
  logic        di;

  assign cs = bus.io_SPI_CS;
  assign di = bus.io_SPI_DI;

`ifdef SPI_RX_CRC7_CHECK_EN
  logic [6:0] crc_calc;

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic d);
    logic fb;
    fb = c[6] ^ d;
    crc7_next = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Running CRC covers start bit through argument LSB; restarts on each start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_calc <= 7'd0;
    end else if (!cs) begin
      case (state)
        S_IDLE:                 if (!di) crc_calc <= crc7_next(7'd0, di);
        S_TXBIT, S_CMD, S_ARG:  crc_calc <= crc7_next(crc_calc, di);
        default:                crc_calc <= crc_calc;
      endcase
    end
  end

  assign crc_ok = (crc_rx == crc_calc);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = di ? S_IDLE : S_TXBIT;
      S_TXBIT: state_nxt = di ? S_CMD : S_IDLE;
      S_CMD:   state_nxt = (counter == 6'd5)  ? S_ARG : S_CMD;
      S_ARG:   state_nxt = (counter == 6'd31) ? S_CRC : S_ARG;
      S_CRC:   state_nxt = (counter == 6'd6)  ? S_END : S_CRC;
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (cs) state_nxt = S_IDLE;
  end

  // Every transition into a new state leaves the counter at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter  <= 6'd0;
      command  <= 6'd0;
      argument <= 32'd0;
      crc_rx   <= 7'd0;
      cmd_done <= 1'b0;
      arg_done <= 1'b0;
      read_ok  <= 1'b0;
    end else if (cs) begin
      counter <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          counter <= 6'd0;
          if (!di) begin
            command  <= 6'd0;
            argument <= 32'd0;
            cmd_done <= 1'b0;
            arg_done <= 1'b0;
            read_ok  <= 1'b0;
          end
        end
        S_TXBIT: counter <= 6'd0;
        S_CMD: begin
          command <= {command[4:0], di};
          if (counter == 6'd5) begin
            cmd_done <= 1'b1;
            counter  <= 6'd0;
          end else begin
            counter <= counter + 6'd1;
          end
        end
        S_ARG: begin
          argument <= {argument[30:0], di};
          if (counter == 6'd31) begin
            arg_done <= 1'b1;
            counter  <= 6'd0;
          end else begin
            counter <= counter + 6'd1;
          end
        end
        S_CRC: begin
          crc_rx  <= {crc_rx[5:0], di};
          counter <= (counter == 6'd6) ? 6'd0 : counter + 6'd1;
        end
        S_END: begin
          read_ok <= di & crc_ok;
          counter <= 6'd0;
        end
        default: counter <= 6'd0;
      endcase
    end
  end

  always_comb begin
    bus.io_SPI_DO               = cs ? 1'b1 : bus.io_DO;
    bus.io_DI                   = di;
    bus.io_CommandReadFinished  = cmd_done;
    bus.io_ArgumentReadFinished = arg_done;
    bus.io_ReadSuccess          = read_ok;
    bus.io_Command              = command;
    bus.io_CommandArgument      = argument;
    bus.io____state             = state;
    bus.io____counter           = counter[2:0];
  end

endmodule

// File: tb/tb_spi_command_receiver.sv
// Bench for spi_command_receiver: directed SD frames plus randomized traffic against a bit-position model.
module tb_spi_command_receiver;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clock = ~clock;

  spi_command_receiver_if bus();

  spi_command_receiver dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Model: bits since the accepted start bit, indexed by edge number k (start bit = 1).
  bit          m_b [1:48];
  int          m_k      = 0;
  bit          m_active = 1'b0;
  int          m_state  = 0;
  int          m_cnt    = 0;
  bit          m_crf    = 1'b0;
  bit          m_arf    = 1'b0;
  bit          m_rs     = 1'b0;
  logic [31:0] m_cmd    = '0;
  logic [31:0] m_arg    = '0;

  function automatic logic [31:0] field(int lo, int hi);
    logic [31:0] v = '0;
    for (int i = lo; i <= hi; i++) v = {v[30:0], m_b[i]};
    return v;
  endfunction

  function automatic logic [6:0] crc7_of(logic [39:0] bits);
    logic [6:0] c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      if (c[6] ^ bits[i]) c = {c[5:0], 1'b0} ^ 7'h09;
      else                c = {c[5:0], 1'b0};
    end
    return c;
  endfunction

  function automatic bit model_crc_ok();
`ifdef SPI_RX_CRC7_CHECK_EN
    logic [39:0] v = '0;
    for (int i = 1; i <= 40; i++) v = {v[38:0], m_b[i]};
    return crc7_of(v) == field(41, 47);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 0; m_k = 0; m_state = 0; m_cnt = 0;
      m_crf = 0; m_arf = 0; m_rs = 0; m_cmd = 0; m_arg = 0;
    end else if (bus.io_SPI_CS) begin
      m_active = 0; m_state = 0; m_cnt = 0;
    end else if (!m_active) begin
      m_state = 0; m_cnt = 0;
      if (!bus.io_SPI_DI) begin
        m_active = 1; m_k = 1; m_b[1] = 0; m_state = 1;
        m_crf = 0; m_arf = 0; m_rs = 0; m_cmd = 0; m_arg = 0;
      end
    end else begin
      m_k++;
      m_b[m_k] = bus.io_SPI_DI;
      if (m_k == 2 && !bus.io_SPI_DI) begin
        m_active = 0; m_state = 0; m_cnt = 0;
      end else begin
        if (m_k >= 3 && m_k <= 8)  m_cmd = field(3, m_k);
        if (m_k >= 9 && m_k <= 40) m_arg = field(9, m_k);
        if (m_k == 8)  m_crf = 1;
        if (m_k == 40) m_arf = 1;
        if (m_k <= 7)       begin m_state = 2; m_cnt = m_k - 2; end
        else if (m_k <= 39) begin m_state = 3; m_cnt = (m_k - 8) & 7; end
        else if (m_k <= 46) begin m_state = 4; m_cnt = m_k - 40; end
        else if (m_k == 47) begin m_state = 5; m_cnt = 0; end
        else begin
          m_rs = m_b[48] && model_crc_ok();
          m_active = 0; m_state = 0; m_cnt = 0;
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      check("state",   32'(bus.io____state),   32'(m_state));
      check("counter", 32'(bus.io____counter), 32'(m_cnt));
      check("crf",     32'(bus.io_CommandReadFinished),  32'(m_crf));
      check("arf",     32'(bus.io_ArgumentReadFinished), 32'(m_arf));
      check("rs",      32'(bus.io_ReadSuccess), 32'(m_rs));
      check("command", 32'(bus.io_Command), m_cmd);
      check("arg",     bus.io_CommandArgument, m_arg);
      check("spi_do",  32'(bus.io_SPI_DO), 32'(bus.io_SPI_CS ? 1'b1 : bus.io_DO));
      check("di_pass", 32'(bus.io_DI), 32'(bus.io_SPI_DI));
    end
  end

  task automatic drive(bit cs, bit di);
    @(negedge clock);
    bus.io_SPI_CS = cs;
    bus.io_SPI_DI = di;
    bus.io_DO     = 1'($urandom);
  endtask

  task automatic send_bits(logic [47:0] f, int n);
    for (int i = 47; i > 47 - n; i--) drive(1'b0, f[i]);
  endtask

  function automatic logic [47:0] mk_frame(logic [5:0] cmd, logic [31:0] arg, bit good_crc,
                                            logic [6:0] bad_crc, bit endb);
    logic [39:0] head = {2'b01, cmd, arg};
    return {head, good_crc ? crc7_of(head) : bad_crc, endb};
  endfunction

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  initial begin
    logic [47:0] f;
    bus.io_SPI_CS = 1'b0;
    bus.io_SPI_DI = 1'b1;
    bus.io_DO     = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (8) drive(1'b0, 1'b1);
    settle();
    check("reset_state", 32'(bus.io____state), 0);
    check("reset_flags", 32'({bus.io_CommandReadFinished, bus.io_ArgumentReadFinished, bus.io_ReadSuccess}), 0);
    check("reset_cmd",   32'(bus.io_Command), 0);
    check("reset_arg",   bus.io_CommandArgument, 0);

    // CMD0 with edge-exact flag timing
    f = 48'h400000000095;
    for (int j = 1; j <= 48; j++) begin
      drive(1'b0, f[48 - j]);
      settle();
      if (j == 7)  check("cmd0_crf_e7",  32'(bus.io_CommandReadFinished), 0);
      if (j == 8)  check("cmd0_crf_e8",  32'(bus.io_CommandReadFinished), 1);
      if (j == 39) check("cmd0_arf_e39", 32'(bus.io_ArgumentReadFinished), 0);
      if (j == 40) check("cmd0_arf_e40", 32'(bus.io_ArgumentReadFinished), 1);
      if (j == 47) check("cmd0_rs_e47",  32'(bus.io_ReadSuccess), 0);
      if (j == 48) check("cmd0_rs_e48",  32'(bus.io_ReadSuccess), 1);
    end
    check("cmd0_state", 32'(bus.io____state), 0);
    check("cmd0_cmd",   32'(bus.io_Command), 0);

    send_bits(48'h48000001AA87, 48);
    settle();
    check("cmd8_cmd", 32'(bus.io_Command), 8);
    check("cmd8_arg", bus.io_CommandArgument, 32'h000001AA);
    check("cmd8_rs",  32'(bus.io_ReadSuccess), 1);

    drive(1'b0, 1'b1);
    send_bits({2'b01, 6'd59, 32'h0001F790, 7'h55, 1'b0}, 48);
    settle();
    check("cmd59_cmd",   32'(bus.io_Command), 59);
    check("cmd59_arg",   bus.io_CommandArgument, 32'h0001F790);
    check("cmd59_flags", 32'({bus.io_CommandReadFinished, bus.io_ArgumentReadFinished}), 3);
    check("cmd59_rs",    32'(bus.io_ReadSuccess), 0);

    send_bits(48'h400000000097, 48);
    settle();
`ifdef SPI_RX_CRC7_CHECK_EN
    check("badcrc_rs", 32'(bus.io_ReadSuccess), 0);
`else
    check("badcrc_rs", 32'(bus.io_ReadSuccess), 1);
`endif

    // CS abort during the argument, then a clean frame
    send_bits(48'h48000001AA87, 20);
    drive(1'b1, 1'b0);
    settle();
    check("cs_abort_state", 32'(bus.io____state), 0);
    check("cs_abort_arf",   32'(bus.io_ArgumentReadFinished), 0);
    drive(1'b0, 1'b1);
    send_bits(48'h48000001AA87, 48);
    settle();
    check("after_cs_rs", 32'(bus.io_ReadSuccess), 1);

    // Async reset during the argument
    send_bits(48'h48000001AA87, 25);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_abort_state", 32'(bus.io____state), 0);
    check("rst_abort_cmd",   32'(bus.io_Command), 0);
    check("rst_abort_arg",   bus.io_CommandArgument, 0);
    check("rst_abort_crf",   32'(bus.io_CommandReadFinished), 0);
    bus.io_SPI_DI = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    send_bits(48'h400000000095, 48);
    settle();
    check("after_rst_rs", 32'(bus.io_ReadSuccess), 1);

    for (int it = 0; it < 60; it++) begin
      int gap = $urandom_range(0, 3);
      int kind = $urandom_range(0, 9);
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b1);
      f = mk_frame(6'($urandom), $urandom, $urandom_range(0, 3) != 0, 7'($urandom),
                   $urandom_range(0, 3) != 0);
      if (kind == 0) begin
        send_bits(48'h0, 2);
      end else if (kind == 1) begin
        send_bits(f, $urandom_range(1, 47));
        repeat ($urandom_range(1, 3)) drive(1'b1, 1'($urandom));
      end else begin
        send_bits(f, 48);
      end
    end
    repeat (4) drive(1'b0, 1'b1);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_command_receiver.md
# spi_command_receiver

SPI-mode SD command-frame receiver clocked directly by the host SPI clock. It deserialises the 48-bit command frame (start, transmission, 6-bit command index, 32-bit argument, CRC7, end bit) arriving on the data-in line. It exposes the command, argument and completion flags to the card-side command decoder, and passes the card's response bit out to the data-out line.

## Interface
Parameters: none.
- clock  in  1  SPI clock; all sampling on rising edge
- reset  in  1  asynchronous, active-high reset
- io_SPI_CS  in  1  chip select, active low
- io_SPI_DI  in  1  serial data from host (MOSI)
- io_SPI_DO  out  1  serial data to host (MISO)
- io_DO  in  1  response bit from card logic, driven onto io_SPI_DO
- io_DI  out  1  raw io_SPI_DI passthrough to card logic
- io_CommandReadFinished  out  1  command index fully received
- io_ArgumentReadFinished  out  1  argument fully received
- io_ReadSuccess  out  1  complete, valid frame received
- io_Command  out  6  command index
- io_CommandArgument  out  32  command argument
- io____state  out  3  debug: FSM state encoding
- io____counter  out  3  debug: low 3 bits of field bit counter

## Operation
- Combinational outputs:
  - io_SPI_DO = io_SPI_CS ? 1 : io_DO.
  - io_DI = io_SPI_DI.
- FSM states (encoding): IDLE=0, TXBIT=1, CMD=2, ARG=3, CRC=4, END=5. Values 6 and 7 are unused and go to IDLE.
- IDLE: DI=1 stays in IDLE (idle fill). DI=0 is the start bit: clear all three flags, Command and CommandArgument, then go to TXBIT.
- TXBIT: DI=1 goes to CMD with counter=0. DI=0 returns to IDLE with flags left cleared.
- CMD: 6 bits, MSB first, shifted into io_Command (Command <= {Command[4:0], DI}). On the 6th bit, set CommandReadFinished and go to ARG.
- ARG: 32 bits, MSB first, shifted into io_CommandArgument. On the 32nd bit, set ArgumentReadFinished and go to CRC.
- CRC: 7 bits captured into an internal CRC register, MSB first, then go to END.
- END: sample the end bit. ReadSuccess is set if the end bit is 1 and, when checking is compiled in, the CRC matches. Always return to IDLE.
- Internal bit counter is 6 bits. It resets to 0 on each state entry and increments per bit in CMD/ARG/CRC. io____counter = counter[2:0].
- Flags, Command and CommandArgument hold their values until the next start bit or reset. During shifting, Command and CommandArgument show partial values; they are valid only once their flag is set.
- CS high sampled on any rising edge forces IDLE. Flags and data registers are untouched, so a partially received frame is abandoned with its flags still low.

## Timing
- Reset (async, any time, including mid-frame): state IDLE, counter 0, all flags 0, Command 0, CommandArgument 0, CRC register 0.
- One bit is sampled per rising edge; there is no oversampling.
- Flag latencies, counted from the start-bit edge (edge 1):
  - CommandReadFinished rises on edge 8.
  - ArgumentReadFinished rises on edge 40.
  - ReadSuccess rises on edge 48.
- Flags are levels, not pulses, and are cleared on the edge that samples the next start bit.
- Back-to-back frames: a start bit is accepted on the edge immediately after END.

## Configuration
- SPI_RX_CRC7_CHECK_EN defined:
  - CRC7 (poly x^7+x^3+1, init 0) is computed over the 40 bits from start bit through argument LSB.
  - It is compared with the 7 received CRC bits; ReadSuccess requires a match plus end bit = 1.
- Not defined: CRC bits are captured but ignored, and ReadSuccess depends only on the end bit = 1.

## Test plan
- Reset with DI=1, then 8 idle clocks -> state 0, all flags 0, Command 0, CommandArgument 0.
- Frame 0x40 00 00 00 00 95 (CMD0, arg 0, CRC 0x4A) -> Command=0; CommandReadFinished at edge 8, ArgumentReadFinished at edge 40, ReadSuccess at edge 48; state back to 0.
- Frame 0x48 00 00 01 AA 87 (CMD8) -> Command=8, CommandArgument=0x000001AA, ReadSuccess=1.
- CMD 123&0x3F=59 with argument 128912 (0x0001F790), 7 CRC bits sent, then end bit 0 -> Command=59, CommandArgument=0x0001F790, both read flags 1, ReadSuccess 0.
- With SPI_RX_CRC7_CHECK_EN, CMD0 frame with CRC byte 0x97 -> ReadSuccess 0. Without the macro -> ReadSuccess 1.
- Assert reset or raise CS during ARG -> state 0 immediately (reset) or at the next edge (CS). A following valid frame is received correctly.
